slv_guard_txn_tracker: RTL
==========================

# slv_guard_txn_tracker

Parametrised outstanding-transaction tracker for the slave guard. It follows one AXI direction (AR/R or AW/B) by observing request and response handshakes, and keeps per-transaction age counters in a slot table with per-ID ordering. Counters advance on a prescaled tick; when a transaction exceeds a runtime budget, the block raises a sticky interrupt and captures the offending ID. It instantiates once per direction inside the guard, and its stall output gates the upstream ready.

## Interface
- `IdWidth`, 4: width of the AXI ID.
- `NumSlots`, 8: table entries, i.e. the total outstanding transactions tracked (≥1).
- `MaxTxnsPerId`, 4: maximum outstanding transactions per ID (≥1, ≤NumSlots).
- `CntWidth`, 8: width of the age counter and of the budget.
- `PrescalerDiv`, 32: clock cycles per tick (≥1).
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous reset, active-high. One clock domain only.
- `en_i` in 1: enable. Low means table cleared, prescaler held at 0, no flags set.
- `budget_i` in CntWidth: timeout threshold in ticks. 0 disables timeout detection.
- `irq_clr_i` in 1: one-cycle pulse that clears `irq_o`, `timeout_o`, `unexp_o` and `err_id_o`.
- `req_valid_i`, `req_ready_i` in 1: observed request handshake.
- `req_id_i` in IdWidth: request ID.
- `rsp_valid_i`, `rsp_ready_i`, `rsp_last_i` in 1: observed response handshake. B is tied with last=1.
- `rsp_id_i` in IdWidth: response ID.
- `stall_o` out 1: combinational. High when the table is full, or when `req_id_i` already has MaxTxnsPerId outstanding.
- `busy_o` out 1: any slot valid.
- `outstanding_o` out $clog2(NumSlots+1): count of valid slots.
- `irq_o` out 1: sticky; OR of `timeout_o` and `unexp_o`.
- `timeout_o` out 1: sticky; at least one slot exceeded its budget.
- `unexp_o` out 1: sticky; a response arrived with no matching slot.
- `err_id_o` out IdWidth: ID of the first error since the last clear.

## Operation
- **Slot fields:** `valid`, `id`, `pos` ($clog2(MaxTxnsPerId) bits, order within the ID), `cnt` (CntWidth bits), `tout`.
- **Allocate** on `req_valid_i & req_ready_i & en_i`:
  - Target is the lowest-index slot that is free in the pre-edge state.
  - `pos` is set to the number of valid slots with the same ID; `cnt` and `tout` are cleared.
  - A handshake while `stall_o` is high is a protocol violation: the request is dropped, `unexp_o` is set, and `err_id_o` captures the request ID.
- **Release** on `rsp_valid_i & rsp_ready_i & rsp_last_i`:
  - The slot whose `id` matches and whose `pos` is 0 is freed.
  - All other valid slots with that ID decrement `pos`.
  - No match sets `unexp_o` and captures `rsp_id_i`.
  - Non-last beats have no effect.
- **Same-cycle allocate and release:** both are evaluated on the pre-edge state.
  - If the IDs are equal, the new `pos` is the same-ID count minus 1.
  - The freed slot cannot be reused in that cycle.
  - A response cannot match a request accepted in the same cycle; it is flagged unexpected.
- **Prescaler:** counts 0..PrescalerDiv-1 while `en_i` is high. `tick` fires when the count is PrescalerDiv-1, then the count wraps to 0. With PrescalerDiv=1, `tick` fires every cycle.
- **Aging:** on `tick`, every valid slot sets `cnt` to cnt+1, saturating at 2^CntWidth-1. A slot allocated in a tick cycle starts at 0.
- **Timeout:** when `budget_i`≠0, the updated `cnt` is ≥`budget_i` and `tout` is 0:
  - `tout` is set and `timeout_o` is set.
  - `err_id_o` is written only if no error is already captured.
  - A timed-out slot stays tracked and is still released normally.
- **Multiple errors in one cycle:** the lowest slot index wins. A timeout outranks an unexpected response.
- **`irq_clr_i`:** takes priority over new errors in the same cycle, so those errors are lost. `tout` bits are not cleared, so the same slot never re-raises.
- **Budget changes:** a `budget_i` change takes effect at the next tick.

## Timing
- **Reset values:** all slots invalid; prescaler 0; `irq_o`, `timeout_o`, `unexp_o`, `busy_o` 0; `outstanding_o` 0; `err_id_o` 0. `stall_o` is 0 after reset.
- **Output latency:**
  - Flags and `err_id_o` are registered and visible in the cycle after the causing edge.
  - `outstanding_o` and `busy_o` are registered and reflect the handshake from the previous cycle.
  - `stall_o` is combinational from the registered table and `req_id_i`, with zero latency.
- **Timeout latency:** `irq_o` rises one cycle after the budget-th tick following allocation.
- **`en_i` deassert:** next edge clears slots and prescaler; sticky flags hold.
- **Reset mid-operation:** all state is cleared immediately (asynchronous).

## Test plan
- **Single timeout:** PrescalerDiv=4, budget=3, en from reset, one request ID=2 at cycle 10, no response → `timeout_o`/`irq_o` rise after the third tick; `err_id_o`=2; `outstanding_o`=1.
- **In-order release:** requests ID=1 ×3, then ID=5, then three last-responses ID=1 → slots free in allocation order; `outstanding_o` goes 4→1; no flags.
- **Per-ID limit and full table:**
  - 4 requests ID=3 → `stall_o`=1 for `req_id_i`=3 and 0 for ID=4.
  - Fill 8 slots → `stall_o`=1 for any ID.
  - Forced handshake while stalled → `unexp_o`=1.
- **Unexpected response:** last-response ID=7 with the table empty → `unexp_o`=1, `err_id_o`=7. An `irq_clr_i` pulse in the same cycle as a timeout leaves the flags clear.
- **Simultaneous events:** same-cycle request ID=1 and last-response ID=1 with one slot ID=1 outstanding → the old slot is freed, the new slot gets `pos` 0, `outstanding_o` stays 1; `budget_i`=0 yields no timeout at saturation (cnt=255).
- **Reset and disable:** assert `rst_i` mid-count with 5 slots valid → all outputs zero immediately. Deassert `en_i` → table cleared on the next edge while `irq_o` holds.

Source files
------------

// File: rtl/slv_guard_txn_tracker.sv
// Outstanding-transaction tracker for one AXI direction: per-ID ordered slot table,
// prescaled age counters, budget timeout and unexpected-response detection.
module slv_guard_txn_tracker #(
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned NumSlots     = 8,
    parameter int unsigned MaxTxnsPerId = 4,
    parameter int unsigned CntWidth     = 8,
    parameter int unsigned PrescalerDiv = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [CntWidth-1:0]           budget_i,
    input  logic                          irq_clr_i,
    input  logic                          req_valid_i,
    input  logic                          req_ready_i,
    input  logic [IdWidth-1:0]            req_id_i,
    input  logic                          rsp_valid_i,
    input  logic                          rsp_ready_i,
    input  logic                          rsp_last_i,
    input  logic [IdWidth-1:0]            rsp_id_i,
    output logic                          stall_o,
    output logic                          busy_o,
    output logic [$clog2(NumSlots+1)-1:0] outstanding_o,
    output logic                          irq_o,
    output logic                          timeout_o,
    output logic                          unexp_o,
    output logic [IdWidth-1:0]            err_id_o
);
    localparam int unsigned OutW = $clog2(NumSlots + 1);
    localparam int unsigned IdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int unsigned PosW = (MaxTxnsPerId > 1) ? $clog2(MaxTxnsPerId) : 1;
    localparam int unsigned PsW  = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

    logic [NumSlots-1:0] valid_q, valid_d, tout_q, tout_d;
    logic [IdWidth-1:0]  id_q  [NumSlots];
    logic [IdWidth-1:0]  id_d  [NumSlots];
    logic [PosW-1:0]     pos_q [NumSlots];
    logic [PosW-1:0]     pos_d [NumSlots];
    logic [CntWidth-1:0] cnt_q [NumSlots];
    logic [CntWidth-1:0] cnt_d [NumSlots];
    logic [PsW-1:0]      presc_q;

    logic                full, found_free, rel_hit, tout_found;
    logic [IdxW-1:0]     free_idx, rel_idx;
    logic [OutW-1:0]     same_cnt, outstanding_d;
    logic [IdWidth-1:0]  tout_id, err_id_d;
    logic                tick, alloc, viol, rel, unmatched, timeout_d, unexp_d;

    // Pre-edge table lookups: first free slot, same-ID count, release match.
    always_comb begin
        found_free = 1'b0;
        free_idx   = '0;
        same_cnt   = '0;
        rel_hit    = 1'b0;
        rel_idx    = '0;
        for (int i = 0; i < int'(NumSlots); i++) begin
            if (!valid_q[i] && !found_free) begin
                found_free = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (valid_q[i] && id_q[i] == req_id_i) begin
                same_cnt = same_cnt + OutW'(1);
            end
            if (valid_q[i] && id_q[i] == rsp_id_i && pos_q[i] == '0 && !rel_hit) begin
                rel_hit = 1'b1;
                rel_idx = IdxW'(i);
            end
        end
        full = !found_free;
    end

    assign stall_o   = full || (same_cnt >= OutW'(MaxTxnsPerId));
    assign tick      = en_i && (presc_q == PsW'(PrescalerDiv - 1));
    assign alloc     = en_i && req_valid_i && req_ready_i && !stall_o;
    assign viol      = en_i && req_valid_i && req_ready_i && stall_o;
    assign rel       = en_i && rsp_valid_i && rsp_ready_i && rsp_last_i && rel_hit;
    assign unmatched = en_i && rsp_valid_i && rsp_ready_i && rsp_last_i && !rel_hit;

    // Next table state: aging/timeout, release with pos shift, allocation, flags.
    always_comb begin
        valid_d    = valid_q;
        tout_d     = tout_q;
        id_d       = id_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        tout_found = 1'b0;
        tout_id    = '0;
        for (int i = 0; i < int'(NumSlots); i++) begin
            if (tick && valid_q[i]) begin
                if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + CntWidth'(1);
                end
                if (budget_i != '0 && cnt_d[i] >= budget_i && !tout_q[i]) begin
                    tout_d[i] = 1'b1;
                    if (!tout_found) begin
                        tout_found = 1'b1;
                        tout_id    = id_q[i];
                    end
                end
            end
            if (rel && valid_q[i] && id_q[i] == rsp_id_i) begin
                if (IdxW'(i) == rel_idx) begin
                    valid_d[i] = 1'b0;
                end else begin
                    pos_d[i] = pos_q[i] - PosW'(1);
                end
            end
            if (alloc && IdxW'(i) == free_idx) begin
                valid_d[i] = 1'b1;
                id_d[i]    = req_id_i;
                pos_d[i]   = (rel && rsp_id_i == req_id_i) ? PosW'(same_cnt - OutW'(1))
                                                           : PosW'(same_cnt);
                cnt_d[i]   = '0;
                tout_d[i]  = 1'b0;
            end
            if (!en_i) begin
                valid_d[i] = 1'b0;
                tout_d[i]  = 1'b0;
                cnt_d[i]   = '0;
                pos_d[i]   = '0;
            end
        end

        outstanding_d = '0;
        for (int i = 0; i < int'(NumSlots); i++) begin
            outstanding_d = outstanding_d + OutW'(valid_d[i]);
        end

        timeout_d = timeout_o || tout_found;
        unexp_d   = unexp_o || unmatched || viol;
        err_id_d  = err_id_o;
        if (!(timeout_o || unexp_o)) begin
            if (tout_found)     err_id_d = tout_id;
            else if (unmatched) err_id_d = rsp_id_i;
            else if (viol)      err_id_d = req_id_i;
        end
        if (irq_clr_i) begin
            timeout_d = 1'b0;
            unexp_d   = 1'b0;
            err_id_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            tout_q        <= '0;
            presc_q       <= '0;
            busy_o        <= 1'b0;
            outstanding_o <= '0;
            irq_o         <= 1'b0;
            timeout_o     <= 1'b0;
            unexp_o       <= 1'b0;
            err_id_o      <= '0;
            for (int i = 0; i < int'(NumSlots); i++) begin
                id_q[i]  <= '0;
                pos_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            tout_q        <= tout_d;
            id_q          <= id_d;
            pos_q         <= pos_d;
            cnt_q         <= cnt_d;
            presc_q       <= (!en_i || tick) ? '0 : presc_q + PsW'(1);
            busy_o        <= (outstanding_d != '0);
            outstanding_o <= outstanding_d;
            irq_o         <= timeout_d || unexp_d;
            timeout_o     <= timeout_d;
            unexp_o       <= unexp_d;
            err_id_o      <= err_id_d;
        end
    end
endmodule
